// File: rtl/counter_cmd_arbiter.sv
// counter_cmd_arbiter
// Round-robin arbiter that lets NUM_REQ requesters share one load/enable
// counter datapath. Each granted command (LOAD value or COUNT n steps) owns
// the counter's set/ena/din controls until it completes. All outputs except
// req_ready_o are registered.

module counter_cmd_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic [NUM_REQ-1:0]            req_op_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    output logic                          ctr_set_o,
    output logic                          ctr_ena_o,
    output logic [DATA_WIDTH-1:0]         ctr_din_o,
    output logic                          busy_o,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id_o,
    output logic                          cmd_done_o
);

    localparam int IDW = $clog2(NUM_REQ);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_COUNT = 2'd2;

    localparam logic [DATA_WIDTH-1:0] STEP_ONE = DATA_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0] STEP_TWO = DATA_WIDTH'(2);
    localparam logic [IDW:0]          NUM_REQ_W = (IDW+1)'(NUM_REQ);

    // Registered state
    logic [1:0]            state_q,    state_d;
    logic [DATA_WIDTH-1:0] step_q,     step_d;
    logic [IDW-1:0]        last_q,     last_d;
    logic [IDW-1:0]        grant_id_q, grant_id_d;
    logic                  ctr_set_q,  ctr_set_d;
    logic                  ctr_ena_q,  ctr_ena_d;
    logic [DATA_WIDTH-1:0] ctr_din_q,  ctr_din_d;
    logic                  busy_q,     busy_d;
    logic                  cmd_done_q, cmd_done_d;

    // Arbitration signals
    logic [IDW:0]          scan_sum [NUM_REQ];
    logic [IDW-1:0]        scan_idx [NUM_REQ];
    logic [DATA_WIDTH-1:0] req_data_arr [NUM_REQ];
    logic                  win_found;
    logic [IDW-1:0]        win_id;
    logic                  win_op;
    logic [DATA_WIDTH-1:0] win_data;
    logic                  is_idle;
    logic                  handshake;

    assign is_idle = (state_q == ST_IDLE);

    // Unpack the flat data bus and build the round-robin scan order
    // last+1, last+2, ... (mod NUM_REQ) without a divider.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_scan
            assign req_data_arr[gi] = req_data_i[gi*DATA_WIDTH +: DATA_WIDTH];
            assign scan_sum[gi]     = {1'b0, last_q} + (IDW+1)'(gi + 1);
            assign scan_idx[gi]     = (scan_sum[gi] >= NUM_REQ_W)
                                    ? IDW'(scan_sum[gi] - NUM_REQ_W)
                                    : scan_sum[gi][IDW-1:0];
        end
    endgenerate

    // Pick the first valid requester in round-robin order
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!win_found && req_valid_i[scan_idx[k]]) begin
                win_found = 1'b1;
                win_id    = scan_idx[k];
            end
        end
    end

    assign win_op    = req_op_i[win_id];
    assign win_data  = req_data_arr[win_id];
    assign handshake = is_idle && win_found;

    // Ready is offered only to the winner and only while idle
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign req_ready_o[gi] = handshake && (win_id == IDW'(gi));
        end
    endgenerate

    // Next-state and registered-output logic for the command sequencer
    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        last_d     = last_q;
        grant_id_d = grant_id_q;
        ctr_din_d  = ctr_din_q;
        ctr_set_d  = 1'b0;
        ctr_ena_d  = 1'b0;
        busy_d     = 1'b0;
        cmd_done_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (handshake) begin
                    last_d     = win_id;
                    grant_id_d = win_id;
                    busy_d     = 1'b1;
                    if (!win_op) begin
                        // LOAD completes in its single active cycle
                        state_d    = ST_LOAD;
                        ctr_set_d  = 1'b1;
                        ctr_din_d  = win_data;
                        cmd_done_d = 1'b1;
                    end else begin
                        // COUNT n: n=0 still spends one cycle in COUNT
                        state_d    = ST_COUNT;
                        step_d     = win_data;
                        ctr_ena_d  = (win_data != '0);
                        cmd_done_d = (win_data <= STEP_ONE);
                    end
                end
            end
            ST_LOAD: begin
                state_d = ST_IDLE;
            end
            ST_COUNT: begin
                // step_q holds the enable cycles remaining including this one
                if (step_q <= STEP_ONE) begin
                    state_d = ST_IDLE;
                    step_d  = '0;
                end else begin
                    step_d     = step_q - STEP_ONE;
                    busy_d     = 1'b1;
                    ctr_ena_d  = 1'b1;
                    cmd_done_d = (step_q == STEP_TWO);
                end
            end
            default: begin
                state_d = ST_IDLE;
                step_d  = '0;
            end
        endcase
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            step_q     <= '0;
            last_q     <= IDW'(NUM_REQ - 1);
            grant_id_q <= '0;
            ctr_set_q  <= 1'b0;
            ctr_ena_q  <= 1'b0;
            ctr_din_q  <= '0;
            busy_q     <= 1'b0;
            cmd_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            last_q     <= last_d;
            grant_id_q <= grant_id_d;
            ctr_set_q  <= ctr_set_d;
            ctr_ena_q  <= ctr_ena_d;
            ctr_din_q  <= ctr_din_d;
            busy_q     <= busy_d;
            cmd_done_q <= cmd_done_d;
        end
    end

    assign ctr_set_o  = ctr_set_q;
    assign ctr_ena_o  = ctr_ena_q;
    assign ctr_din_o  = ctr_din_q;
    assign busy_o     = busy_q;
    assign grant_id_o = grant_id_q;
    assign cmd_done_o = cmd_done_q;

endmodule

// File: tb/tb_counter_cmd_arbiter.sv
// Self-checking bench for counter_cmd_arbiter: directed steps plus a random
// phase, with a scoreboard of accepted commands checked at each cmd_done.

module tb_counter_cmd_arbiter;

    localparam int N  = 2;
    localparam int DW = 8;

    logic              clk;
    logic              rst_n;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N-1:0]      req_op;
    logic [N*DW-1:0]   req_data;
    logic              ctr_set;
    logic              ctr_ena;
    logic [DW-1:0]     ctr_din;
    logic              busy;
    logic [0:0]        grant_id;
    logic              cmd_done;

    counter_cmd_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_op_i    (req_op),
        .req_data_i  (req_data),
        .ctr_set_o   (ctr_set),
        .ctr_ena_o   (ctr_ena),
        .ctr_din_o   (ctr_din),
        .busy_o      (busy),
        .grant_id_o  (grant_id),
        .cmd_done_o  (cmd_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    typedef struct {
        int id;
        bit op;
        int data;
    } exp_t;
    exp_t sb[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference round-robin pick: first valid scanning last+1, last+2, ...
    function automatic int rr_pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (last + k) % N;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    // Counter datapath model driven by the DUT controls
    logic [DW-1:0] ctr_m = '0;
    always @(posedge clk) begin
        if (ctr_set)      ctr_m <= ctr_din;
        else if (ctr_ena) ctr_m <= ctr_m + 8'd1;
    end

    // Monitor: arbitration model, protocol checks, scoreboard push/pop
    int  last_m = N - 1;
    bit  in_cmd = 0;
    bit  post_done = 0;
    int  cur_id, cyc, ena_cnt, set_cnt;
    always @(negedge clk) begin
        int   win;
        exp_t e;
        logic [N-1:0] exp_ready;
        if (!rst_n) begin
            last_m    = N - 1;
            in_cmd    = 0;
            post_done = 0;
            sb.delete();
        end else begin
            win = busy ? -1 : rr_pick(req_valid, last_m);
            exp_ready = (win >= 0) ? N'(1 << win) : '0;
            check("ready_vs_model", 32'(req_ready), 32'(exp_ready));
            check("set_ena_excl", 32'(ctr_set & ctr_ena), 32'd0);
            if (win >= 0) begin
                e.id   = win;
                e.op   = req_op[win];
                e.data = int'(req_data[win*DW +: DW]);
                sb.push_back(e);
                last_m = win;
            end
            if (post_done) begin
                check("idle_after_done", 32'(busy), 32'd0);
                post_done = 0;
            end
            if (busy && !in_cmd) begin
                in_cmd  = 1;
                cur_id  = int'(grant_id);
                cyc     = 0;
                ena_cnt = 0;
                set_cnt = 0;
            end
            if (in_cmd) begin
                cyc++;
                ena_cnt += int'(ctr_ena);
                set_cnt += int'(ctr_set);
                if (cmd_done) begin
                    check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        check("cmd_grant_id", 32'(cur_id), 32'(e.id));
                        if (!e.op) begin
                            check("load_set_cnt", 32'(set_cnt), 32'd1);
                            check("load_din", 32'(ctr_din), 32'(e.data));
                            check("load_cycles", 32'(cyc), 32'd1);
                        end else begin
                            check("count_set_cnt", 32'(set_cnt), 32'd0);
                            check("count_ena_cnt", 32'(ena_cnt), 32'(e.data));
                            check("count_cycles", 32'(cyc), 32'((e.data == 0) ? 1 : e.data));
                        end
                        $display("txn id=%0d op=%0d data=0x%0h cycles=%0d ena=%0d", e.id, e.op, e.data, cyc, ena_cnt);
                    end
                    in_cmd    = 0;
                    post_done = 1;
                end
            end
        end
    end

    // Wait (bounded) for any req_ready at a negedge, then step past the edge
    task automatic wait_ready(output logic [N-1:0] r);
        r = '0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                r = req_ready;
                break;
            end
        end
        check("wait_ready_seen", 32'(r != '0), 32'd1);
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for the FSM to return to IDLE
    task automatic wait_idle();
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (!busy) begin
                seen = 1'b1;
                break;
            end
        end
        check("wait_idle_seen", 32'(seen), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i, input bit v, input bit op, input logic [DW-1:0] d);
        req_valid[i]          = v;
        req_op[i]             = op;
        req_data[i*DW +: DW]  = d;
    endtask

    logic [N-1:0] r;
    logic [N-1:0] hs;

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_op    = '0;
        req_data  = '0;

        // Reset state
        @(negedge clk);
        check("rst_ctr_set", 32'(ctr_set), 32'd0);
        check("rst_ctr_ena", 32'(ctr_ena), 32'd0);
        check("rst_ctr_din", 32'(ctr_din), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_grant_id", 32'(grant_id), 32'd0);
        check("rst_cmd_done", 32'(cmd_done), 32'd0);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: req0 LOAD 0x5A
        drive(0, 1, 0, 8'h5A);
        wait_ready(r);
        check("t1_ready", 32'(r), 32'b01);
        drive(0, 0, 0, 8'h00);
        @(negedge clk);
        check("t1_set", 32'(ctr_set), 32'd1);
        check("t1_din", 32'(ctr_din), 32'h5A);
        check("t1_done", 32'(cmd_done), 32'd1);
        check("t1_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("t1_busy_t2", 32'(busy), 32'd0);
        check("t1_set_t2", 32'(ctr_set), 32'd0);
        @(posedge clk); #1;

        // 2: counter loaded 0xFE, then req1 COUNT 3 -> wraps to 0x01
        drive(0, 1, 0, 8'hFE);
        wait_ready(r);
        drive(0, 0, 0, 8'h00);
        wait_idle();
        drive(1, 1, 1, 8'd3);
        wait_ready(r);
        check("t2_ready", 32'(r), 32'b10);
        drive(1, 0, 0, 8'h00);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            check("t2_ena", 32'(ctr_ena), 32'd1);
            check("t2_done", 32'(cmd_done), 32'(c == 3));
        end
        @(negedge clk);
        check("t2_ena_after", 32'(ctr_ena), 32'd0);
        check("t2_ctr_wrap", 32'(ctr_m), 32'h01);
        @(posedge clk); #1;

        // 3: both requesters continuously valid with COUNT 1 -> alternate
        drive(0, 1, 1, 8'd1);
        drive(1, 1, 1, 8'd1);
        for (int g = 0; g < 4; g++) begin
            wait_ready(r);
            check("t3_ready", 32'(r), 32'(1 << (g % 2)));
            if (g == 3) req_valid = '0;
            @(negedge clk);
            check("t3_grant_id", 32'(grant_id), 32'(g % 2));
        end
        wait_idle();

        // 4: COUNT 0 then COUNT 255
        drive(0, 1, 1, 8'd0);
        wait_ready(r);
        check("t4_ready", 32'(r), 32'b01);
        drive(0, 0, 0, 8'h00);
        @(negedge clk);
        check("t4_busy", 32'(busy), 32'd1);
        check("t4_ena", 32'(ctr_ena), 32'd0);
        check("t4_done", 32'(cmd_done), 32'd1);
        @(negedge clk);
        check("t4_busy_t2", 32'(busy), 32'd0);
        @(posedge clk); #1;
        drive(1, 1, 1, 8'd255);
        wait_ready(r);
        drive(1, 0, 0, 8'h00);
        wait_idle();

        // 5: reset in the middle of COUNT 10
        drive(0, 1, 1, 8'd10);
        wait_ready(r);
        drive(0, 0, 0, 8'h00);
        repeat (4) begin
            @(negedge clk);
            check("t5_ena", 32'(ctr_ena), 32'd1);
        end
        #1 rst_n = 1'b0;
        #1;
        check("t5_ena_abort", 32'(ctr_ena), 32'd0);
        check("t5_busy_abort", 32'(busy), 32'd0);
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        drive(0, 1, 0, 8'h11);
        drive(1, 1, 0, 8'h22);
        wait_ready(r);
        check("t5_first_after_rst", 32'(r), 32'b01);
        req_valid = '0;
        @(negedge clk);
        check("t5_din", 32'(ctr_din), 32'h11);
        wait_idle();

        // 6: random traffic under requester rules; monitor checks protocol
        hs = '0;
        for (int cyc_i = 0; cyc_i < 400; cyc_i++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || hs[i]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        if ($urandom_range(0, 1) == 0)
                            drive(i, 1, 0, DW'($urandom_range(0, 255)));
                        else
                            drive(i, 1, 1, DW'($urandom_range(0, 5)));
                    end else begin
                        req_valid[i] = 1'b0;
                    end
                end else if ($urandom_range(0, 7) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            @(negedge clk);
            hs = req_valid & req_ready;
            @(posedge clk); #1;
        end
        req_valid = '0;
        wait_idle();
        @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
